// File: rtl/riscv_pkg.sv
// Shared constants and address type for the RISC-V integer register file.
package riscv_pkg;

    localparam int RV_NREGS_I = 32;
    localparam int RV_NREGS_E = 16;
    localparam int RV_AW_MAX  = 5;

    typedef logic [RV_AW_MAX-1:0] rv_reg_addr_t;

    // True for a writable/readable architectural register (x0 and out-of-range excluded).
    function automatic logic rv_addr_live(input rv_reg_addr_t addr, input int nregs);
        return (addr != '0) && (int'(addr) < nregs);
    endfunction

endpackage

// File: rtl/riscv_gpr_scoreboard.sv
// Pending-write scoreboard: one bit per GPR, set by a reservation, cleared by a write.
module riscv_gpr_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rsv_i,
    input  logic [AW-1:0]           rsv_a_i,
    input  logic [NWR-1:0]          we_i,
    input  logic [NWR-1:0][AW-1:0]  wa_i,
    input  logic [NRD-1:0][AW-1:0]  ra_i,
    input  logic [NRD-1:0]          fwd_i,
    output logic [NRD-1:0]          busy_o
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Clears are applied first so a same-cycle reservation of the same register wins.
    always_comb begin
        pend_d = pend_q;
        for (int k = 0; k < NWR; k++) begin
            if (we_i[k] && rv_addr_live(rv_reg_addr_t'(wa_i[k]), NREGS)) begin
                pend_d[wa_i[k]] = 1'b0;
            end
        end
        if (rsv_i && rv_addr_live(rv_reg_addr_t'(rsv_a_i), NREGS)) begin
            pend_d[rsv_a_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!rst_i && !fwd_i[i] && rv_addr_live(rv_reg_addr_t'(ra_i[i]), NREGS)) begin
                busy_o[i] = pend_q[ra_i[i]];
            end
        end
    end

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-ported RISC-V GPR file with optional write-to-read forwarding and a
// pending-write scoreboard for in-flight destinations.
module riscv_regfile_mp
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NWR-1:0]           we_i,
    input  logic [NWR-1:0][AW-1:0]   wa_i,
    input  logic [NWR-1:0][XLEN-1:0] wd_i,
    input  logic [NRD-1:0][AW-1:0]   ra_i,
    output logic [NRD-1:0][XLEN-1:0] rd_o,
    output logic [NRD-1:0]           rbusy_o,
    input  logic                     rsv_i,
    input  logic [AW-1:0]            rsv_a_i
);

    if (!((NREGS == RV_NREGS_I || NREGS == RV_NREGS_E) &&
          NRD >= 1 && NRD <= 4 && NWR >= 1 && NWR <= 2 &&
          (BYPASS == 0 || BYPASS == 1))) begin : g_param_check
        $error("riscv_regfile_mp: illegal parameters NREGS=%0d NRD=%0d NWR=%0d BYPASS=%0d",
               NREGS, NRD, NWR, BYPASS);
    end

    logic [XLEN-1:0] gpr_q [NREGS];
    logic [XLEN-1:0] gpr_d [NREGS];
    logic [NRD-1:0]  fwd;

    // Ascending port order makes the highest-index writer win on a collision.
    // NOTE: always_comb uses blocking '=' so later statements see earlier
    // updates; every target gets a default first so no latch is inferred.
    always_comb begin
        gpr_d = gpr_q;
        for (int k = 0; k < NWR; k++) begin
            if (we_i[k] && rv_addr_live(rv_reg_addr_t'(wa_i[k]), NREGS)) begin
                gpr_d[wa_i[k]] = wd_i[k];
            end
        end
        gpr_d[0] = '0;
    end

    // NOTE: the array is cleared on reset because software may read any GPR
    // straight after reset and expects zero; this costs a reset net per flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                gpr_q[r] <= '0;
            end
        end else begin
            gpr_q <= gpr_d;
        end
    end

    always_comb begin
        rd_o = '0;
        fwd  = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!rst_i && rv_addr_live(rv_reg_addr_t'(ra_i[i]), NREGS)) begin
                rd_o[i] = gpr_q[ra_i[i]];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NWR; k++) begin
                        if (we_i[k] && wa_i[k] == ra_i[i]) begin
                            rd_o[i] = wd_i[k];
                            fwd[i]  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    riscv_gpr_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rsv_i   (rsv_i),
        .rsv_a_i (rsv_a_i),
        .we_i    (we_i),
        .wa_i    (wa_i),
        .ra_i    (ra_i),
        .fwd_i   (fwd),
        .busy_o  (rbusy_o)
    );

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Bench for riscv_regfile_mp: an RV32I instance (2R/2W, forwarding) and an RV32E
// instance (4R/1W, no forwarding) compared against an array-based model.
module tb_riscv_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: NREGS=32, NRD=2, NWR=2, BYPASS=1
    logic [1:0]       we_a;
    logic [1:0][4:0]  wa_a;
    logic [1:0][31:0] wd_a;
    logic [1:0][4:0]  ra_a;
    logic [1:0][31:0] rd_a;
    logic [1:0]       rbusy_a;
    logic             rsv_a;
    logic [4:0]       rsv_addr_a;

    // Instance B: NREGS=16, NRD=4, NWR=1, BYPASS=0
    logic [0:0]       we_b;
    logic [0:0][3:0]  wa_b;
    logic [0:0][31:0] wd_b;
    logic [3:0][3:0]  ra_b;
    logic [3:0][31:0] rd_b;
    logic [3:0]       rbusy_b;
    logic             rsv_b;
    logic [3:0]       rsv_addr_b;

    riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .we_i(we_a), .wa_i(wa_a), .wd_i(wd_a),
        .ra_i(ra_a), .rd_o(rd_a), .rbusy_o(rbusy_a), .rsv_i(rsv_a), .rsv_a_i(rsv_addr_a)
    );

    riscv_regfile_mp #(.XLEN(32), .NREGS(16), .NRD(4), .NWR(1), .BYPASS(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .we_i(we_b), .wa_i(wa_b), .wd_i(wd_b),
        .ra_i(ra_b), .rd_o(rd_b), .rbusy_o(rbusy_b), .rsv_i(rsv_b), .rsv_a_i(rsv_addr_b)
    );

    logic [31:0] m_a [32];
    bit          p_a [32];
    logic [31:0] m_b [16];
    bit          p_b [16];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void clear_model();
        for (int r = 0; r < 32; r++) begin
            m_a[r] = '0;
            p_a[r] = 1'b0;
        end
        for (int r = 0; r < 16; r++) begin
            m_b[r] = '0;
            p_b[r] = 1'b0;
        end
    endfunction

    // Expected read of A: latest same-cycle write data if any, else stored value.
    function automatic logic [31:0] exp_rd_a(input logic [4:0] ra, output logic busy);
        logic [31:0] v;
        bit fw = 0;
        busy = 1'b0;
        if (rst || ra == 0) return '0;
        v = m_a[ra];
        for (int k = 0; k < 2; k++) begin
            if (we_a[k] && wa_a[k] == ra) begin
                v  = wd_a[k];
                fw = 1;
            end
        end
        busy = p_a[ra] && !fw;
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        logic [31:0] ev;
        logic        eb;
        for (int i = 0; i < 2; i++) begin
            ev = exp_rd_a(ra_a[i], eb);
            check($sformatf("%s_a_rd%0d", tag, i), rd_a[i], ev);
            check($sformatf("%s_a_busy%0d", tag, i), {31'b0, rbusy_a[i]}, {31'b0, eb});
        end
        for (int i = 0; i < 4; i++) begin
            ev = (rst || ra_b[i] == 0) ? 32'h0 : m_b[ra_b[i]];
            eb = (rst || ra_b[i] == 0) ? 1'b0 : p_b[ra_b[i]];
            check($sformatf("%s_b_rd%0d", tag, i), rd_b[i], ev);
            check($sformatf("%s_b_busy%0d", tag, i), {31'b0, rbusy_b[i]}, {31'b0, eb});
        end
    endtask

    // Check before the edge, let the edge happen, fold the inputs into the model, check again.
    task automatic step(input string tag);
        #1 check_outputs({tag, "_pre"});
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (we_a[k] && wa_a[k] != 0) m_a[wa_a[k]] = wd_a[k];
            end
            for (int k = 0; k < 2; k++) begin
                if (we_a[k]) p_a[wa_a[k]] = 1'b0;
            end
            if (rsv_a && rsv_addr_a != 0) p_a[rsv_addr_a] = 1'b1;
            if (we_b[0] && wa_b[0] != 0) begin
                m_b[wa_b[0]] = wd_b[0];
                p_b[wa_b[0]] = 1'b0;
            end
            if (rsv_b && rsv_addr_b != 0) p_b[rsv_addr_b] = 1'b1;
        end
        #1 check_outputs({tag, "_post"});
    endtask

    task automatic idle();
        we_a = '0; wa_a = '0; wd_a = '0; rsv_a = 1'b0; rsv_addr_a = '0;
        we_b = '0; wa_b = '0; wd_b = '0; rsv_b = 1'b0; rsv_addr_b = '0;
    endtask

    // Mid-cycle asynchronous reset pulse.
    task automatic reset_pulse(input string tag);
        #2 rst = 1'b1;
        clear_model();
        #1 check_outputs(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        idle();
        ra_a = '0;
        ra_b = '0;
        clear_model();
        rst = 1'b1;

        // Reset state
        ra_a = {5'd9, 5'd5};
        #1 check_outputs("reset");
        check("reset_x5", rd_a[0], 32'h0);
        #12 rst = 1'b0;

        // First edge after reset takes the write; reserve x6 alongside
        we_a = 2'b01; wa_a[0] = 5'd5; wd_a[0] = 32'hDEADBEEF;
        rsv_a = 1'b1; rsv_addr_a = 5'd6;
        ra_a = {5'd6, 5'd5};
        step("w5");
        idle();
        #1 check("w5_value", rd_a[0], 32'hDEADBEEF);
        check("w5_rsv6_busy", {31'b0, rbusy_a[1]}, 32'h1);

        // Asynchronous reset mid-cycle clears data and reservations
        #1 rst = 1'b1;
        clear_model();
        #1 check("rst_x5", rd_a[0], 32'h0);
        check("rst_busy6", {31'b0, rbusy_a[1]}, 32'h0);
        #1 rst = 1'b0;
        step("post_rst");
        check("post_rst_busy6", {31'b0, rbusy_a[1]}, 32'h0);

        // Writes to x0 are dropped, with and without forwarding
        we_a = 2'b01; wa_a[0] = 5'd0; wd_a[0] = 32'hFFFFFFFF; ra_a = '0;
        we_b = 1'b1;  wa_b[0] = 4'd0; wd_b[0] = 32'hFFFFFFFF; ra_b = '0;
        #1 check("x0_pre_a", rd_a[0], 32'h0);
        check("x0_pre_b", rd_b[0], 32'h0);
        step("x0");
        check("x0_post_a", rd_a[0], 32'h0);
        check("x0_post_b", rd_b[0], 32'h0);

        // Forwarding vs stored value
        idle();
        we_b = 1'b1; wa_b[0] = 4'd7; wd_b[0] = 32'h0000AAAA;
        step("preload_b7");
        we_a = 2'b01; wa_a[0] = 5'd7; wd_a[0] = 32'h12345678; ra_a[0] = 5'd7;
        we_b = 1'b1;  wa_b[0] = 4'd7; wd_b[0] = 32'h12345678; ra_b[0] = 4'd7;
        #1 check("bypass_a", rd_a[0], 32'h12345678);
        check("nobypass_b", rd_b[0], 32'h0000AAAA);
        step("bypass");
        check("bypass_b_after", rd_b[0], 32'h12345678);

        // Two ports write x3: higher port wins
        idle();
        we_a = 2'b11; wa_a = {5'd3, 5'd3}; wd_a = {32'h2222, 32'h1111}; ra_a[0] = 5'd3;
        #1 check("collide_fwd", rd_a[0], 32'h2222);
        step("collide");
        check("collide_store", rd_a[0], 32'h2222);

        // Scoreboard: reserve, clear by write, reserve+write together
        idle();
        rsv_a = 1'b1; rsv_addr_a = 5'd9; ra_a[0] = 5'd9;
        #1 check("rsv9_before", {31'b0, rbusy_a[0]}, 32'h0);
        step("rsv9");
        rsv_a = 1'b0;
        #1 check("rsv9_after", {31'b0, rbusy_a[0]}, 32'h1);
        we_a = 2'b01; wa_a[0] = 5'd9; wd_a[0] = 32'h99;
        #1 check("w9_fwd_notbusy", {31'b0, rbusy_a[0]}, 32'h0);
        step("w9");
        idle();
        #1 check("w9_cleared", {31'b0, rbusy_a[0]}, 32'h0);
        rsv_a = 1'b1; rsv_addr_a = 5'd9;
        we_a = 2'b01; wa_a[0] = 5'd9; wd_a[0] = 32'h999;
        step("rsv_w9");
        idle();
        #1 check("rsv_wins", {31'b0, rbusy_a[0]}, 32'h1);

        // RV32E: only x15 holds data after a fresh reset
        reset_pulse("rst2");
        we_b = 1'b1; wa_b[0] = 4'd15; wd_b[0] = 32'h0000A5A5;
        step("w15");
        idle();
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 4; i++) ra_b[i] = 4'(4 * g + i);
            #1;
            for (int i = 0; i < 4; i++) begin
                check($sformatf("e_x%0d", 4 * g + i), rd_b[i],
                      (4 * g + i == 15) ? 32'h0000A5A5 : 32'h0);
            end
        end

        // Random traffic against the model, with one reset in the middle
        for (int n = 0; n < 300; n++) begin
            if (n == 150) reset_pulse("rst_rand");
            we_a = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                wa_a[k] = 5'($urandom_range(0, 31));
                wd_a[k] = $urandom;
            end
            for (int i = 0; i < 2; i++) ra_a[i] = 5'($urandom_range(0, 31));
            rsv_a = ($urandom_range(0, 3) == 0);
            rsv_addr_a = 5'($urandom_range(0, 31));
            we_b[0] = 1'($urandom);
            wa_b[0] = 4'($urandom_range(0, 15));
            wd_b[0] = $urandom;
            for (int i = 0; i < 4; i++) ra_b[i] = 4'($urandom_range(0, 15));
            rsv_b = ($urandom_range(0, 3) == 0);
            rsv_addr_b = 4'($urandom_range(0, 15));
            step($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
